// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-time program loader. Receives a big-endian byte stream
//               (entry point, word count N, N payload words) over a
//               valid/ready handshake, writes the payload words into memory
//               starting at ADDR_BASE, then releases the CPU with a one-cycle
//               INT pulse and the entry point taken from the stream header.
// Ports       : clk, rst_n          - clock, asynchronous active-low reset
//               in_valid/in_byte    - incoming stream byte
//               in_ready            - loader accepts a byte this cycle
//               mem_addr/mem_wdata  - word write address / data
//               mem_we              - one-cycle write strobe per word
//               entryPoint          - entry address from the header
//               INT                 - one-cycle "load PC" pulse to the CPU
//               cpu_hold            - CPU held while high
//               done / err          - sticky completion / header-error flags
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int ADDR_BASE = 128,
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [31:0] entryPoint,
  output logic        INT,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);

  localparam logic [2:0] S_ENTRY = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0]       r_state;
  logic [1:0]       r_byte_cnt;
  logic [23:0]      r_shift;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_word_cnt;

  logic             w_fire;
  logic             w_last_byte;
  logic             w_all_words;
  logic [31:0]      w_word;

  // Once every payload word has been assembled, the only remaining LOAD
  // cycle is the write of the last word; no further byte may be taken.
  assign w_all_words = (r_word_cnt == r_count);

  assign in_ready = (r_state == S_ENTRY) || (r_state == S_COUNT) ||
                    ((r_state == S_LOAD) && !w_all_words);

  assign w_fire      = in_valid && in_ready;
  assign w_last_byte = w_fire && (r_byte_cnt == 2'd3);
  // Complete big-endian word on the cycle its fourth byte arrives.
  assign w_word      = {r_shift, in_byte};

  assign INT      = (r_state == S_START);
  assign cpu_hold = !((r_state == S_START) || (r_state == S_DONE));
  assign done     = (r_state == S_DONE);
  assign err      = (r_state == S_ERROR);

  // Byte assembly: counter wraps 3->0 on each completed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
    end else if (w_fire) begin
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {r_shift[15:0], in_byte};
    end
  end

  // Control FSM and registered memory write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_ENTRY;
      r_count    <= '0;
      r_word_cnt <= '0;
      entryPoint <= 32'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      case (r_state)
        S_ENTRY: begin
          if (w_last_byte) begin
            entryPoint <= w_word;
            r_state    <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_last_byte) begin
            if (w_word == 32'd0) begin
              r_state <= S_START;
            end else if (w_word > 32'(MAX_WORDS)) begin
              r_state <= S_ERROR;
            end else begin
              r_count <= w_word[CNT_W-1:0];
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (w_all_words) begin
            // This is the write cycle of the last word.
            r_state <= S_START;
          end else if (w_last_byte) begin
            mem_we     <= 1'b1;
            mem_addr   <= 32'(ADDR_BASE) + (32'(r_word_cnt) << 2);
            mem_wdata  <= w_word;
            r_word_cnt <= r_word_cnt + CNT_W'(1);
          end
        end
        S_START: begin
          r_state <= S_DONE;
        end
        S_DONE, S_ERROR: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= S_ERROR;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader. A reference model turns
//               each byte stream into the expected entry point, error status
//               and list of memory writes; a negedge monitor pops and checks
//               writes and the INT pulse as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int ADDR_BASE = 128;
  localparam int MAX_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'd0;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] entryPoint;
  logic        INT;
  logic        cpu_hold;
  logic        done;
  logic        err;

  prog_loader #(
    .ADDR_BASE(ADDR_BASE),
    .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .entryPoint(entryPoint),
    .INT       (INT),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         e_pop;
  logic [7:0]  stream[$];
  logic [31:0] exp_entry = 32'd0;
  int          exp_n = 0;
  bit          exp_err = 1'b0;
  bit          exp_int = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_accept = -10;
  int last_we = -10;
  int int_count = 0;
  bit gap_phase = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_write: actual addr=%h data=%h required no write", mem_addr, mem_wdata);
        end else begin
          e_pop = exp_q.pop_front();
          check("write_addr", mem_addr, e_pop.addr);
          check("write_data", mem_wdata, e_pop.data);
        end
        check("write_after_4th_byte", cyc, last_accept + 1);
        last_we = cyc;
      end
      if (INT) begin
        int_count++;
        check("int_expected", 32'd1, {31'd0, exp_int});
        check("int_entry", entryPoint, exp_entry);
        check("int_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("int_timing", cyc, ((exp_n == 0) ? last_accept : last_we) + 1);
        check("int_writes_drained", exp_q.size(), 32'd0);
      end
      if (in_valid && in_ready) last_accept = cyc;
    end
  end

  // ---------------- reference model ----------------
  task automatic push_word(input logic [31:0] w);
    stream.push_back(w[31:24]);
    stream.push_back(w[23:16]);
    stream.push_back(w[15:8]);
    stream.push_back(w[7:0]);
  endtask

  task automatic load_model();
    logic [31:0] n;
    wr_t e;
    exp_entry = {stream[0], stream[1], stream[2], stream[3]};
    n         = {stream[4], stream[5], stream[6], stream[7]};
    exp_err   = (n > 32'(MAX_WORDS));
    exp_int   = !exp_err;
    exp_n     = exp_err ? 0 : int'(n);
    for (int i = 0; i < exp_n; i++) begin
      e.addr = 32'(ADDR_BASE) + 32'(4 * i);
      e.data = {stream[8+4*i], stream[9+4*i], stream[10+4*i], stream[11+4*i]};
      exp_q.push_back(e);
    end
  endtask

  // ---------------- drivers ----------------
  // mode 0: continuous, 1: alternating gaps, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit sent;
    sent = 1'b0;
    for (int t = 0; t < 200 && !sent; t++) begin
      @(posedge clk);
      #1;
      gap_phase = ~gap_phase;
      if ((mode == 1 && gap_phase) || (mode == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_byte  = b;
        sent     = in_ready;
      end
    end
    if (!sent) begin
      checks++;
      failures++;
      $display("FAIL byte_accept_timeout: actual in_ready=0 required 1 for byte %h", b);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_bytes(input int count, input int mode);
    for (int i = 0; i < count; i++) send_byte(stream[i], mode);
    idle();
  endtask

  task automatic check_reset();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_entry", entryPoint, 32'd0);
    check("rst_int", {31'd0, INT}, 32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
  endtask

  // Asserted between clock edges to exercise the asynchronous path.
  task automatic do_reset();
    @(negedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset();
    exp_q.delete();
    exp_int     = 1'b0;
    exp_err     = 1'b0;
    exp_n       = 0;
    exp_entry   = 32'd0;
    int_count   = 0;
    last_accept = -10;
    last_we     = -10;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic finish_check(input string tag);
    bit ended;
    ended = 1'b0;
    for (int t = 0; t < 300 && !ended; t++) begin
      @(negedge clk);
      ended = done || err;
    end
    if (!ended) begin
      checks++;
      failures++;
      $display("FAIL %s_end_timeout: actual done=0 err=0 required one set", tag);
    end
    check({tag, "_done"}, {31'd0, done}, {31'd0, !exp_err});
    check({tag, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({tag, "_entry"}, entryPoint, exp_entry);
    check({tag, "_int_count"}, int_count, exp_int ? 32'd1 : 32'd0);
    check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, exp_err});
  endtask

  task automatic build_nominal();
    stream.delete();
    push_word(32'h0000_0080);
    push_word(32'h0000_0002);
    push_word(32'h2008_0005);
    push_word(32'h0109_5020);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int n;
    do_reset();

    // Nominal stream, in_valid held high.
    build_nominal();
    load_model();
    send_bytes(stream.size(), 0);
    finish_check("nominal");

    // Extra bytes after done are ignored.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      check("postdone_in_ready", {31'd0, in_ready}, 32'd0);
    end
    idle();
    repeat (3) @(negedge clk);
    check("postdone_entry", entryPoint, 32'h0000_0080);
    check("postdone_int_count", int_count, 32'd1);
    check("postdone_done", {31'd0, done}, 32'd1);

    // Gapped input, alternating valid.
    do_reset();
    build_nominal();
    load_model();
    send_bytes(stream.size(), 1);
    finish_check("gapped");

    // Zero count.
    do_reset();
    stream.delete();
    push_word(32'h0000_0100);
    push_word(32'h0000_0000);
    load_model();
    send_bytes(stream.size(), 0);
    finish_check("zero");

    // Overflow count.
    do_reset();
    stream.delete();
    push_word(32'h0000_0000);
    push_word(32'h0000_0101);
    load_model();
    send_bytes(stream.size(), 0);
    finish_check("overflow");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!cpu_hold || in_ready || !err || INT || mem_we) bad++;
    end
    check("overflow_hold_50", bad, 32'd0);

    // Reset mid-load after 2 bytes of payload word 1, then replay.
    do_reset();
    build_nominal();
    load_model();
    for (int i = 0; i < 14; i++) send_byte(stream[i], 0);
    do_reset();
    build_nominal();
    load_model();
    send_bytes(stream.size(), 0);
    finish_check("replay");

    // Randomized streams with random gaps.
    for (int it = 0; it < 6; it++) begin
      do_reset();
      stream.delete();
      push_word($urandom);
      if (it == 3) begin
        push_word(32'($urandom_range(MAX_WORDS + 1, 100000)));
      end else begin
        n = $urandom_range(0, 5);
        push_word(32'(n));
        for (int w = 0; w < n; w++) push_word($urandom);
      end
      load_model();
      send_bytes(stream.size(), 2);
      finish_check("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual simulation still running required finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
